// File: rtl/fp32_pkg.sv
// Shared FP32 field widths, constants, flag positions and pipeline stage types
// used by the multiplier and adder datapaths.
package fp32_pkg;

  localparam int EXP_W    = 8;
  localparam int MAN_W    = 23;
  localparam int SIG_W    = MAN_W + 1;
  localparam int PROD_W   = 2 * SIG_W;
  localparam int EXPS_W   = 10;
  localparam int EXP_BIAS = 127;

  localparam logic [31:0] QNAN = 32'h7FC0_0000;

  localparam int FLAG_W         = 3;
  localparam int FLAG_INVALID   = 2;
  localparam int FLAG_OVERFLOW  = 1;
  localparam int FLAG_UNDERFLOW = 0;

  // Working exponent is signed and wide enough for eA+eB-127 plus two carries.
  typedef logic signed [EXPS_W-1:0] exps_t;

  localparam exps_t EXPS_ZERO = '0;
  localparam exps_t EXPS_ONE  = 10'sd1;
  localparam exps_t EXPS_BIAS = 10'sd127;
  localparam exps_t EXPS_MAX  = 10'sd255;

  typedef enum logic [1:0] {
    FP_NORM = 2'd0,
    FP_ZERO = 2'd1,
    FP_INF  = 2'd2,
    FP_NAN  = 2'd3
  } fp_class_t;

  typedef struct packed {
    logic              sign;
    exps_t             exp;
    logic [PROD_W-1:0] prod;
    fp_class_t         cls;
  } mul_s1_t;

  typedef struct packed {
    logic             sign;
    exps_t            exp;
    logic [SIG_W-1:0] sig;
    logic             guard;
    logic             round;
    logic             sticky;
    fp_class_t        cls;
  } mul_s2_t;

  // Denormals classify as zero so they are flushed before any arithmetic.
  function automatic fp_class_t classify(input logic [31:0] x);
    if (x[30:23] == '1) begin
      return (x[22:0] != '0) ? FP_NAN : FP_INF;
    end
    if (x[30:23] == '0) begin
      return FP_ZERO;
    end
    return FP_NORM;
  endfunction

endpackage

// File: rtl/fp32_round_pack.sv
// Rounds a normalised 24-bit significand with guard/round/sticky (nearest, ties-to-even),
// applies the carry to the exponent and packs an FP32 word, saturating to zero or infinity.
module fp32_round_pack
  import fp32_pkg::*;
(
  input  logic                     sign,
  input  logic signed [EXPS_W-1:0] exp,
  input  logic [SIG_W-1:0]         sig,
  input  logic                     guard,
  input  logic                     round,
  input  logic                     sticky,
  output logic [31:0]              word,
  output logic                     overflow,
  output logic                     underflow
);

  logic                     round_up;
  logic [SIG_W:0]           sig_rnd;
  logic signed [EXPS_W-1:0] exp_rnd;
  logic [MAN_W-1:0]         man;

  always_comb begin
    round_up = guard & (round | sticky | sig[0]);
    sig_rnd  = {1'b0, sig} + {{SIG_W{1'b0}}, round_up};

    // A carry out of the significand means it became exactly 2.0.
    exp_rnd  = sig_rnd[SIG_W] ? (exp + EXPS_ONE) : exp;
    man      = sig_rnd[SIG_W] ? sig_rnd[MAN_W:1] : sig_rnd[MAN_W-1:0];

    overflow  = 1'b0;
    underflow = 1'b0;
    word      = {sign, exp_rnd[EXP_W-1:0], man};

    if (exp_rnd <= EXPS_ZERO) begin
      underflow = 1'b1;
      word      = {sign, {(EXP_W + MAN_W){1'b0}}};
    end else if (exp_rnd >= EXPS_MAX) begin
      overflow = 1'b1;
      word     = {sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    end
  end

endmodule

// File: rtl/fp32_mul_pipe.sv
// Three-stage FP32 multiplier (unpack/multiply, normalise, round/pack); 3-cycle latency.
// One global advance enable freezes every stage while a held result is not consumed.
module fp32_mul_pipe #(
  parameter logic [31:0] QNAN = fp32_pkg::QNAN
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] result,
  output logic [2:0]  flags
);

  import fp32_pkg::*;

  logic      adv;
  fp_class_t cls_a;
  fp_class_t cls_b;

  logic    s1_vld;
  logic    s2_vld;
  mul_s1_t s1;
  mul_s1_t s1_nxt;
  mul_s2_t s2;
  mul_s2_t s2_nxt;

  logic [31:0]       rp_word;
  logic              rp_overflow;
  logic              rp_underflow;
  logic [31:0]       res_nxt;
  logic [FLAG_W-1:0] flg_nxt;

  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;

  // Stage 1: classify, sign, biased exponent sum and full significand product.
  always_comb begin
    cls_a  = classify(A);
    cls_b  = classify(B);
    s1_nxt = '0;

    s1_nxt.sign = A[31] ^ B[31];
    s1_nxt.exp  = exps_t'({2'b00, A[30:23]}) + exps_t'({2'b00, B[30:23]}) - EXPS_BIAS;
    s1_nxt.prod = {{SIG_W{1'b0}}, 1'b1, A[22:0]} * {{SIG_W{1'b0}}, 1'b1, B[22:0]};

    if (cls_a == FP_NAN || cls_b == FP_NAN ||
        (cls_a == FP_INF && cls_b == FP_ZERO) ||
        (cls_a == FP_ZERO && cls_b == FP_INF)) begin
      s1_nxt.cls = FP_NAN;
    end else if (cls_a == FP_INF || cls_b == FP_INF) begin
      s1_nxt.cls = FP_INF;
    end else if (cls_a == FP_ZERO || cls_b == FP_ZERO) begin
      s1_nxt.cls = FP_ZERO;
    end else begin
      s1_nxt.cls = FP_NORM;
    end
  end

  // Stage 2: the product of two [1,2) significands lies in [1,4); fold [2,4) down.
  always_comb begin
    s2_nxt      = '0;
    s2_nxt.sign = s1.sign;
    s2_nxt.cls  = s1.cls;

    if (s1.prod[PROD_W-1]) begin
      s2_nxt.exp    = s1.exp + EXPS_ONE;
      s2_nxt.sig    = s1.prod[PROD_W-1 -: SIG_W];
      s2_nxt.guard  = s1.prod[PROD_W-SIG_W-1];
      s2_nxt.round  = s1.prod[PROD_W-SIG_W-2];
      s2_nxt.sticky = |s1.prod[PROD_W-SIG_W-3:0];
    end else begin
      s2_nxt.exp    = s1.exp;
      s2_nxt.sig    = s1.prod[PROD_W-2 -: SIG_W];
      s2_nxt.guard  = s1.prod[PROD_W-SIG_W-2];
      s2_nxt.round  = s1.prod[PROD_W-SIG_W-3];
      s2_nxt.sticky = |s1.prod[PROD_W-SIG_W-4:0];
    end
  end

  // Stage 3: round and pack, then let special operands override the arithmetic.
  fp32_round_pack u_round_pack (
    .sign      (s2.sign),
    .exp       (s2.exp),
    .sig       (s2.sig),
    .guard     (s2.guard),
    .round     (s2.round),
    .sticky    (s2.sticky),
    .word      (rp_word),
    .overflow  (rp_overflow),
    .underflow (rp_underflow)
  );

  always_comb begin
    res_nxt = rp_word;
    flg_nxt = '0;
    unique case (s2.cls)
      FP_NAN: begin
        res_nxt                = QNAN;
        flg_nxt[FLAG_INVALID]  = 1'b1;
      end
      FP_INF: begin
        res_nxt = {s2.sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      end
      FP_ZERO: begin
        res_nxt = {s2.sign, {(EXP_W + MAN_W){1'b0}}};
      end
      default: begin
        flg_nxt[FLAG_OVERFLOW]  = rp_overflow;
        flg_nxt[FLAG_UNDERFLOW] = rp_underflow;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_vld    <= 1'b0;
      s2_vld    <= 1'b0;
      out_valid <= 1'b0;
      s1        <= '0;
      s2        <= '0;
      result    <= '0;
      flags     <= '0;
    end else if (adv) begin
      s1_vld    <= in_valid;
      s2_vld    <= s1_vld;
      out_valid <= s2_vld;
      s1        <= s1_nxt;
      s2        <= s2_nxt;
      if (s2_vld) begin
        result <= res_nxt;
        flags  <= flg_nxt;
      end
    end
  end

endmodule

// File: tb/tb_fp32_mul_pipe.sv
// Directed bench for fp32_mul_pipe: an integer-arithmetic reference model feeds a
// scoreboard that a single negedge monitor compares against every consumed product.
module tb_fp32_mul_pipe;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] A = '0;
  logic [31:0] B = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] result;
  logic [2:0]  flags;

  fp32_mul_pipe #(.QNAN(32'h7FC0_0000)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .A         (A),
    .B         (B),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .flags     (flags)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  bit lat_mode = 1'b0;

  typedef struct {
    logic [34:0] expv;
    int          acc_cyc;
    bit          timed;
  } exp_t;
  exp_t exp_q[$];

  localparam int NV = 19;
  // {flags, result} expectations worked out by hand.
  logic [31:0] va [NV] = '{32'h4000_0000, 32'h3F80_0001, 32'h3FC0_0000, 32'h7F80_0000, 32'h7F00_0000,
                           32'h0080_0000, 32'h8000_0000, 32'h3F80_0001, 32'h3F80_0003, 32'h3FFF_FFFE,
                           32'h7F80_0001, 32'hFF80_0000, 32'h0040_0000, 32'h0080_0000, 32'h0080_0000,
                           32'h7F7F_FFFF, 32'h8080_0000, 32'hC000_0000, 32'h8000_0000};
  logic [31:0] vb [NV] = '{32'h4040_0000, 32'h3F80_0001, 32'h3FC0_0000, 32'h0000_0000, 32'h4000_0000,
                           32'h0080_0000, 32'h3F80_0000, 32'h3FC0_0000, 32'h3FC0_0000, 32'h3F80_0001,
                           32'h3F80_0000, 32'h4000_0000, 32'h7F00_0000, 32'h3F80_0000, 32'h3F00_0000,
                           32'h3F80_0001, 32'h0080_0000, 32'h4040_0000, 32'hFF80_0000};
  logic [34:0] ve [NV] = '{{3'b000, 32'h40C0_0000}, {3'b000, 32'h3F80_0002}, {3'b000, 32'h4010_0000},
                           {3'b100, 32'h7FC0_0000}, {3'b010, 32'h7F80_0000}, {3'b001, 32'h0000_0000},
                           {3'b000, 32'h8000_0000}, {3'b000, 32'h3FC0_0002}, {3'b000, 32'h3FC0_0004},
                           {3'b000, 32'h4000_0000}, {3'b100, 32'h7FC0_0000}, {3'b000, 32'hFF80_0000},
                           {3'b000, 32'h0000_0000}, {3'b000, 32'h0080_0000}, {3'b001, 32'h0000_0000},
                           {3'b010, 32'h7F80_0000}, {3'b001, 32'h8000_0000}, {3'b000, 32'hC0C0_0000},
                           {3'b100, 32'h7FC0_0000}};

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  // Exact product as an integer, rounded to 24 significant bits by comparing the
  // discarded remainder with half an ulp.
  function automatic logic [34:0] model(input logic [31:0] a, input logic [31:0] b);
    logic        s;
    int          ea, eb, e, sh;
    logic [63:0] p, q, rem, half;
    bit          nan_in, inf_a, inf_b, zero_a, zero_b;
    s      = a[31] ^ b[31];
    ea     = int'(a[30:23]);
    eb     = int'(b[30:23]);
    nan_in = (ea == 255 && a[22:0] != 0) || (eb == 255 && b[22:0] != 0);
    inf_a  = (ea == 255 && a[22:0] == 0);
    inf_b  = (eb == 255 && b[22:0] == 0);
    zero_a = (ea == 0);
    zero_b = (eb == 0);
    if (nan_in || (inf_a && zero_b) || (inf_b && zero_a)) return {3'b100, 32'h7FC0_0000};
    if (inf_a || inf_b) return {3'b000, s, 8'hFF, 23'h0};
    if (zero_a || zero_b) return {3'b000, s, 31'h0};
    p    = {40'h0, 1'b1, a[22:0]} * {40'h0, 1'b1, b[22:0]};
    sh   = (p >= 64'h8000_0000_0000) ? 24 : 23;
    e    = ea + eb - 127 + (sh - 23);
    q    = p >> sh;
    rem  = p - (q << sh);
    half = 64'd1 << (sh - 1);
    if (rem > half || (rem == half && q[0])) q = q + 64'd1;
    if (q == 64'h100_0000) begin
      q = q >> 1;
      e = e + 1;
    end
    if (e <= 0) return {3'b001, s, 31'h0};
    if (e >= 255) return {3'b010, s, 8'hFF, 23'h0};
    return {3'b000, s, e[7:0], q[22:0]};
  endfunction

  task automatic send(input logic [31:0] a, input logic [31:0] b);
    int n = 0;
    bit done = 1'b0;
    A = a;
    B = b;
    in_valid = 1'b1;
    while (!done && n < 200) begin
      @(negedge clk);
      done = in_ready;
      @(posedge clk);
      #1;
      n++;
    end
    in_valid = 1'b0;
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL send_timeout: operands %h*%h not accepted in %0d cycles, 200 allowed", a, b, n);
    end
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 300) begin
      @(posedge clk);
      n++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout: %0d results outstanding, 0 required", exp_q.size());
    end
    @(posedge clk);
    #1;
  endtask

  initial begin : monitor
    bit          held = 1'b0;
    logic [31:0] hr = '0;
    logic [2:0]  hf = '0;
    exp_t        e;
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst_n) begin
        exp_q.delete();
        held = 1'b0;
        continue;
      end
      if (held) begin
        check("stall_out_valid", 64'(out_valid), 64'd1);
        check("stall_result", 64'(result), 64'(hr));
        check("stall_flags", 64'(flags), 64'(hf));
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_output: result %h flags %b, no product outstanding", result, flags);
        end else begin
          e = exp_q.pop_front();
          check("result", 64'(result), 64'(e.expv[31:0]));
          check("flags", 64'(flags), 64'(e.expv[34:32]));
          if (e.timed) check("latency", 64'(cyc - e.acc_cyc), 64'd3);
        end
      end
      if (in_valid && in_ready) exp_q.push_back('{model(A, B), cyc, lat_mode});
      held = out_valid && !out_ready;
      hr   = result;
      hf   = flags;
    end
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation did not complete within 100000 time units");
    $fatal(1);
  end

  initial begin : main
    // Reset values while rst_n is low, ready once released.
    repeat (3) @(posedge clk);
    #1;
    check("reset_out_valid", 64'(out_valid), 64'd0);
    check("reset_result", 64'(result), 64'd0);
    check("reset_flags", 64'(flags), 64'd0);
    #2 rst_n = 1'b1;
    #1;
    check("reset_in_ready", 64'(in_ready), 64'd1);
    @(posedge clk);
    #1;

    for (int i = 0; i < NV; i++) check($sformatf("model_pin_%0d", i), 64'(model(va[i], vb[i])), 64'(ve[i]));

    // Single product into an idle pipe, then every vector back-to-back.
    out_ready = 1'b1;
    lat_mode  = 1'b1;
    send(va[0], vb[0]);
    drain();
    for (int i = 0; i < NV; i++) send(va[i], vb[i]);
    drain();

    // Five inputs against a sink that stalls for six cycles.
    lat_mode  = 1'b0;
    out_ready = 1'b0;
    fork
      begin
        for (int i = 1; i <= 5; i++) send(va[i], vb[i]);
      end
      begin
        repeat (6) @(posedge clk);
        #1;
        check("bp_in_ready", 64'(in_ready), 64'd0);
        check("bp_out_valid", 64'(out_valid), 64'd1);
        check("bp_accepted", 64'(exp_q.size()), 64'd3);
        out_ready = 1'b1;
      end
    join
    drain();

    // Irregular consumer.
    fork
      begin
        for (int i = NV - 1; i >= 0; i--) send(va[i], vb[i]);
      end
      begin
        repeat (60) begin
          @(posedge clk);
          #1;
          out_ready = 1'($urandom_range(0, 1));
        end
        out_ready = 1'b1;
      end
    join
    out_ready = 1'b1;
    drain();

    // Reset with two products in flight, one of them already presented.
    out_ready = 1'b0;
    send(va[0], vb[0]);
    send(va[2], vb[2]);
    @(posedge clk);
    #1;
    check("pre_reset_out_valid", 64'(out_valid), 64'd1);
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", 64'(out_valid), 64'd0);
    check("midrst_result", 64'(result), 64'd0);
    check("midrst_flags", 64'(flags), 64'd0);
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      #1;
      check($sformatf("post_reset_idle_%0d", i), 64'(out_valid), 64'd0);
    end
    lat_mode = 1'b1;
    send(va[17], vb[17]);
    drain();

    check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fp32_mul_pipe.md
FP32_MUL_PIPE -- requirements
Module: fp32_mul_pipe

Interface
REQ-001 SHALL have parameter: QNAN, 32'h7FC0_0000, canonical quiet-NaN pattern emitted for every NaN result.
REQ-002 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port: rst_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port: in_valid  input  1  operand pair A/B present.
REQ-005 SHALL have port: in_ready  output  1  block accepts the operand pair this cycle.
REQ-006 SHALL have port: A  input  32  IEEE754 single-precision multiplicand.
REQ-007 SHALL have port: B  input  32  IEEE754 single-precision multiplier.
REQ-008 SHALL have port: out_valid  output  1  product present on result.
REQ-009 SHALL have port: out_ready  input  1  downstream adder stage consumes result this cycle.
REQ-010 SHALL have port: result  output  32  IEEE754 product A*B.
REQ-011 SHALL have port: flags  output  3  {invalid, overflow, underflow}, aligned with result.

Function
REQ-012 SHALL be a 3-stage pipeline: S1 unpack, sign XOR, 10-bit signed exponent sum (eA+eB-127), 24x24 mantissa product; S2 normalise; S3 round, pack, special-case select.
REQ-013 SHALL have a fixed latency of exactly 3 cycles from an accepted input to out_valid when out_ready is held high.
REQ-014 SHALL define the transfer rule as: input accepted when in_valid && in_ready; output consumed when out_valid && out_ready.
REQ-015 SHALL define the stage-advance enable as adv = !out_valid || out_ready; in_ready = adv; every stage register, including its valid bit, updates only when adv is high.
REQ-016 SHALL hold result, flags and out_valid stable while out_valid && !out_ready; it SHALL NOT drop or duplicate any product.
REQ-017 SHALL sustain a throughput of one product per cycle with out_ready high; it SHALL accept back-to-back inputs.
REQ-018 SHALL, for normalisation with a 48-bit product at or above 2.0 (bit47 set), shift right by 1 and increment the exponent.
REQ-019 SHALL round to nearest, ties-to-even, using guard, round and sticky bits; a mantissa carry-out from rounding SHALL increment the exponent.
REQ-020 SHALL flush denormal inputs (exp==0) to signed zero before multiplication.
REQ-021 SHALL flush a denormal or underflowing result (final exponent <= 0) to signed zero and set underflow.
REQ-022 SHALL return signed infinity 0x7F80_0000|sign<<31 and set overflow when the final exponent >= 255.
REQ-023 SHALL return QNAN with invalid set for a NaN on either input, or for Inf*0.
REQ-024 SHALL return signed infinity with no flag for Inf*finite-nonzero.
REQ-025 SHALL compute result sign as A[31]^B[31] for all non-NaN results, including zero.

Reset
REQ-026 SHALL clear all valid bits and set out_valid=0, result=32'h0, flags=3'b000 immediately while rst_n is low, with in_ready=1 after release.
REQ-027 SHALL discard all in-flight operations on reset asserted mid-operation; after release no stale product SHALL appear.

Structure
REQ-028 SHALL place QNAN, the exponent bias 127, the FP32 field widths and the flag bit indices in the shared package fp32_pkg, also used by the adder stage.
REQ-029 SHALL use one sub-module, fp32_round_pack (normalised mantissa + GRS + exponent -> packed word + flags), reusable by the adder.

Verification
REQ-030 SHALL check: 0x4000_0000 * 0x4040_0000 -> 0x40C0_0000 (6.0), flags 000, out_valid exactly 3 cycles after accept.
REQ-031 SHALL check: 0x3F80_0001 * 0x3F80_0001 -> 0x3F80_0002 (round-to-nearest); 0x3FC0_0000 * 0x3FC0_0000 -> 0x4010_0000 (2.25, normalise shift).
REQ-032 SHALL check: 0x7F80_0000 * 0x0000_0000 -> 0x7FC0_0000, invalid=1; 0x7F00_0000 * 0x4000_0000 -> 0x7F80_0000, overflow=1.
REQ-033 SHALL check: 0x0080_0000 * 0x0080_0000 -> 0x0000_0000, underflow=1; 0x8000_0000 * 0x3F80_0000 -> 0x8000_0000.
REQ-034 SHALL check backpressure: 5 consecutive inputs with out_ready low for 6 cycles -> in_ready low once 3 products are held; all 5 results emerge in order, unchanged while stalled.
REQ-035 SHALL check reset: rst_n pulsed low with 2 products in flight -> out_valid=0 at once, no output until a new input is accepted.
